// File: rtl/tc2sm_seq.sv
`default_nettype none
// ============================================================================
// Module   : tc2sm_seq
// Purpose  : Multicycle two's-complement to sign-magnitude decoder. Negates a
//            negative operand CHUNK bits per cycle (LSB chunk first) using a
//            registered carry, so no full-width incrementer is needed.
//            Latency is WIDTH/CHUNK cycles regardless of the data.
// Ports    : clk, reset (sync, active-high), Flush (sync abort)
//            InValid/InReady, A, Signed         -- operand side
//            OutValid/OutReady, Mag, Sign,
//            Zero, MinNeg                       -- result side
// Revision : 1.0 - initial release
// ============================================================================
module tc2sm_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic             Signed,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Mag,
  output logic             Sign,
  output logic             Zero,
  output logic             MinNeg
);

  localparam int c_N     = WIDTH / CHUNK;
  localparam int c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_BUSY = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [c_IDX_W-1:0] c_LAST   = c_IDX_W'(c_N - 1);
  localparam logic [WIDTH-1:0]   c_MINNEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         state_q,  state_d;
  logic [c_IDX_W-1:0] idx_q,    idx_d;
  logic               carry_q,  carry_d;
  logic [WIDTH-1:0]   mag_q,    mag_d;
  logic               sign_q,   sign_d;
  logic               zero_q,   zero_d;
  logic               minneg_q, minneg_d;

  logic [CHUNK-1:0]   w_chunk;
  logic [CHUNK:0]     w_sum;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    mag_d    = mag_q;
    sign_d   = sign_q;
    zero_d   = zero_q;
    minneg_d = minneg_q;

    // One slice of the ~x + 1 negation; the carry ripples between cycles.
    w_chunk = mag_q[idx_q*CHUNK +: CHUNK];
    w_sum   = {1'b0, ~w_chunk} + {{CHUNK{1'b0}}, carry_q};

    case (state_q)
      c_IDLE: begin
        if (InValid) begin
          mag_d    = A;
          sign_d   = Signed & A[WIDTH-1];
          minneg_d = Signed & (A == c_MINNEG);
          zero_d   = 1'b0;
          idx_d    = '0;
          carry_d  = 1'b1;
          state_d  = c_BUSY;
        end
      end
      c_BUSY: begin
        // Non-negative operands still take N cycles so timing is data-independent.
        if (sign_q) begin
          mag_d[idx_q*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
          carry_d                     = w_sum[CHUNK];
        end
        idx_d = idx_q + c_IDX_W'(1);
        if (idx_q == c_LAST) begin
          zero_d  = (mag_d == '0);
          state_d = c_DONE;
        end
      end
      c_DONE: begin
        if (OutReady) begin
          state_d = c_IDLE;
        end
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase

    // Abort overrides everything; result registers are left as don't-care.
    if (Flush) begin
      state_d = c_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= c_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      mag_q    <= '0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      minneg_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      mag_q    <= mag_d;
      sign_q   <= sign_d;
      zero_q   <= zero_d;
      minneg_q <= minneg_d;
    end
  end

  assign InReady  = (state_q == c_IDLE);
  assign OutValid = (state_q == c_DONE);
  assign Mag      = mag_q;
  assign Sign     = sign_q;
  assign Zero     = zero_q;
  assign MinNeg   = minneg_q;

endmodule
`default_nettype wire

// File: tb/tb_tc2sm_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_tc2sm_seq
// Purpose  : Self-checking bench for tc2sm_seq (WIDTH=32, CHUNK=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tc2sm_seq;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int N_LAT = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             Flush = 1'b0;
  logic             InValid = 1'b0;
  logic             InReady;
  logic [WIDTH-1:0] A = '0;
  logic             Signed = 1'b0;
  logic             OutValid;
  logic             OutReady = 1'b0;
  logic [WIDTH-1:0] Mag;
  logic             Sign;
  logic             Zero;
  logic             MinNeg;

  int checks = 0;
  int errors = 0;

  tc2sm_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk      (clk),
    .reset    (reset),
    .Flush    (Flush),
    .InValid  (InValid),
    .InReady  (InReady),
    .A        (A),
    .Signed   (Signed),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Mag      (Mag),
    .Sign     (Sign),
    .Zero     (Zero),
    .MinNeg   (MinNeg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic             sgn;
    logic [WIDTH-1:0] mag;
    logic             sign;
    logic             zero;
    logic             minneg;
  } vec_t;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t golden(input logic [WIDTH-1:0] a, input logic sgn);
    vec_t v;
    v.a      = a;
    v.sgn    = sgn;
    v.sign   = sgn & a[WIDTH-1];
    v.mag    = v.sign ? (~a + 32'd1) : a;
    v.zero   = (v.mag == 32'd0);
    v.minneg = sgn & (a == 32'h8000_0000);
    return v;
  endfunction

  // Accept one operand with OutReady held high, check latency and the result.
  task automatic run_op(input vec_t v);
    int lat;
    int guard;
    guard = 0;
    while (!InReady && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_op", InReady, 1);
    OutReady = 1'b1;
    InValid  = 1'b1;
    A        = v.a;
    Signed   = v.sgn;
    @(negedge clk);
    InValid  = 1'b0;
    A        = 32'hDEAD_BEEF;
    Signed   = ~v.sgn;
    check("inready_busy", InReady, 0);
    lat = 0;
    while (!OutValid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, N_LAT);
    check("mag", Mag, v.mag);
    check("sign", Sign, v.sign);
    check("zero", Zero, v.zero);
    check("minneg", MinNeg, v.minneg);
    @(negedge clk);
    check("outvalid_clear", OutValid, 0);
    check("mag_hold", Mag, v.mag);
  endtask

  vec_t vecs [9];
  vec_t q[$];
  vec_t e;

  initial begin
    int lat;
    logic seen;
    logic [WIDTH-1:0] mag0;
    int accepted;
    int cyc;

    vecs[0] = '{32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FF00, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h8000_0000, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'h8000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{32'h0001_0000, 1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_inready", InReady, 1);
    check("rst_outvalid", OutValid, 0);
    check("rst_mag", Mag, 0);
    check("rst_sign", Sign, 0);
    check("rst_zero", Zero, 0);
    check("rst_minneg", MinNeg, 0);

    for (int i = 0; i < 9; i++) run_op(vecs[i]);

    // Backpressure: result held stable for 3 DONE cycles.
    OutReady = 1'b0;
    InValid  = 1'b1;
    A        = 32'hFFFF_FFFB;
    Signed   = 1'b1;
    @(negedge clk);
    InValid = 1'b0;
    lat = 0;
    while (!OutValid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", lat, N_LAT);
    for (int k = 0; k < 3; k++) begin
      check("bp_mag", Mag, 32'h0000_0005);
      check("bp_sign", Sign, 1);
      check("bp_inready", InReady, 0);
      check("bp_outvalid", OutValid, 1);
      @(negedge clk);
    end
    OutReady = 1'b1;
    @(negedge clk);
    check("bp_idle", InReady, 1);
    check("bp_outvalid_clr", OutValid, 0);
    run_op(golden(32'hFFFF_FF85, 1'b1));

    // Reset at the 2nd BUSY edge.
    InValid = 1'b1;
    A       = 32'hFFFF_FFF0;
    Signed  = 1'b1;
    @(negedge clk);
    InValid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_inready", InReady, 1);
    check("rst_mid_outvalid", OutValid, 0);
    check("rst_mid_mag", Mag, 0);
    check("rst_mid_sign", Sign, 0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (OutValid) seen = 1'b1;
    end
    check("rst_no_stale", seen, 0);

    // Flush at the 2nd BUSY edge.
    InValid = 1'b1;
    @(negedge clk);
    InValid = 1'b0;
    @(negedge clk);
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    check("flush_inready", InReady, 1);
    check("flush_outvalid", OutValid, 0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (OutValid) seen = 1'b1;
    end
    check("flush_no_stale", seen, 0);

    // Flush in IDLE blocks an offered operand.
    Flush   = 1'b1;
    InValid = 1'b1;
    @(negedge clk);
    Flush   = 1'b0;
    InValid = 1'b0;
    check("flush_idle_noacc", InReady, 1);
    run_op(golden(32'hFFFF_FFFE, 1'b1));

    // Soak with random stalls and a golden-model scoreboard.
    accepted = 0;
    cyc = 0;
    while ((accepted < 3000 || q.size() != 0) && cyc < 60000) begin
      InValid  = (accepted < 3000) ? ($urandom_range(0, 3) != 0) : 1'b0;
      A        = $urandom;
      case ($urandom_range(0, 7))
        0: A = 32'h8000_0000;
        1: A = 32'h0000_0000;
        2: A = 32'hFFFF_FF00 | {24'd0, A[7:0]};
        default: ;
      endcase
      Signed   = $urandom_range(0, 1);
      OutReady = ($urandom_range(0, 2) != 0);
      if (InReady && OutValid) check("soak_ready_valid_excl", 1, 0);
      if (InReady && InValid) begin
        q.push_back(golden(A, Signed));
        accepted++;
      end
      if (OutValid && OutReady) begin
        if (q.size() == 0) begin
          check("soak_spurious_result", 1, 0);
        end else begin
          e = q.pop_front();
          check("soak_mag", Mag, e.mag);
          check("soak_flags", {29'd0, Sign, Zero, MinNeg}, {29'd0, e.sign, e.zero, e.minneg});
        end
      end
      @(negedge clk);
      cyc++;
    end
    InValid = 1'b0;
    check("soak_accepted", accepted, 3000);
    check("soak_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
